// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared encodings for the pipelined immediate generator
//
// Purpose: format-select encodings, the opcode/funct3 constants that qualify
// the shift-amount exception, and a small funct3 helper.
package imm_pkg;

  // Format select carried on in_type; encodings 5..7 are illegal.
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_IMM_32  = 7'b0011011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // True for the funct3 values that turn an I-type immediate into a shamt.
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate format mux with shift exception
//
// Purpose: extract the I/S/B/U/J immediate from a 32-bit instruction and
// sign-extend it to XLEN. OP-IMM shifts (and OP-IMM-32 shifts on RV64)
// yield the zero-extended shift amount instead of the signed I immediate.
//
// Ports:
//   instr  in   32    instruction word
//   fmt    in   3     format select (imm_fmt_e encoding, 5..7 illegal)
//   imm    out  XLEN  extended immediate, 0 for illegal formats
//   err    out  1     fmt was illegal
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  localparam bit RV64 = (XLEN == 64);

  logic [31:0] raw;
  logic [5:0]  shamt;
  logic        use_shamt;

  always_comb begin
    raw       = '0;
    err       = 1'b0;
    shamt     = '0;
    use_shamt = 1'b0;

    // Every legal format is assembled as a 32-bit signed value first; the
    // final step widens it to XLEN by sign extension.
    case (fmt)
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'b0};
      IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: err = 1'b1;
    endcase

    // Only genuine shift opcodes take the shamt path; a load with
    // funct3=101 keeps its signed offset.
    if ((fmt == IMM_I) && is_shift_f3(instr[14:12])) begin
      if (instr[6:0] == OP_IMM) begin
        use_shamt = 1'b1;
        shamt     = RV64 ? instr[25:20] : {1'b0, instr[24:20]};
      end else if (RV64 && (instr[6:0] == OP_IMM_32)) begin
        use_shamt = 1'b1;
        shamt     = {1'b0, instr[24:20]};
      end
    end

    if (use_shamt) begin
      imm = XLEN'(shamt);
    end else begin
      imm = XLEN'($signed(raw));
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with 2-entry skid buffer
//
// Purpose: decode the immediate of each accepted instruction and present it
// one cycle later through a registered valid/ready output stage. A second
// (skid) entry absorbs the item accepted while the output is stalled, so
// in_ready depends only on registered state and never on out_ready.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      upstream has a valid instruction
//   in_ready   out  1      block can accept an instruction this cycle
//   in_instr   in   32     instruction word
//   in_type    in   3      format select, 5..7 illegal
//   in_tag     in   TAG_W  sideband passed through unchanged
//   out_valid  out  1      out_imm/out_err/out_tag are valid
//   out_ready  in   1      downstream accepts the current output
//   out_imm    out  XLEN   extended immediate
//   out_err    out  1      in_type was illegal
//   out_tag    out  TAG_W  tag of the current output
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic             skid_err;
  logic [TAG_W-1:0] skid_tag;

  logic             in_fire;
  logic             out_free;

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr (in_instr),
    .fmt   (in_type),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  // skid_valid is a flop, so in_ready has no combinational path from out_ready.
  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  // The output register may be loaded when it is empty or draining this cycle.
  assign out_free = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_err    <= 1'b0;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_err   <= 1'b0;
      skid_tag   <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        // Oldest item first: the skid entry moves up. in_ready is low while
        // the skid entry is occupied, so no new item arrives this cycle.
        out_valid  <= 1'b1;
        out_imm    <= skid_imm;
        out_err    <= skid_err;
        out_tag    <= skid_tag;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) begin
          out_imm <= dec_imm;
          out_err <= dec_err;
          out_tag <= in_tag;
        end
      end
    end else if (in_fire) begin
      // Output stalled: park the new result; the output register holds.
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_err   <= dec_err;
      skid_tag   <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (RV32 and RV64)
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_type;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [4:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_err(out_err32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_err(out_err64), .out_tag(out_tag64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic [31:0] exp32;
    logic [63:0] exp64;
    logic        err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int q_tag[$];
    int q_imm[$];
    logic [31:0] held_imm32;
    logic [63:0] held_imm64;
    logic [4:0]  held_tag;
    bit stalled;
    int sent, got, et, ei;

    vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // addi -1
    vecs[1]  = '{32'h4030D093, 3'd0, 32'h00000003, 64'h0000000000000003, 1'b0}; // srai 3
    vecs[2]  = '{32'hFFF05083, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0}; // lhu -1
    vecs[3]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0}; // beq -4
    vecs[4]  = '{32'h123450B7, 3'd3, 32'h12345000, 64'h0000000012345000, 1'b0}; // lui
    vecs[5]  = '{32'h03F09093, 3'd0, 32'h0000001F, 64'h000000000000003F, 1'b0}; // slli 63
    vecs[6]  = '{32'h41F0D09B, 3'd0, 32'h0000041F, 64'h000000000000001F, 1'b0}; // sraiw 31
    vecs[7]  = '{32'hFE112C23, 3'd1, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0}; // sw -8
    vecs[8]  = '{32'h0010006F, 3'd4, 32'h00000800, 64'h0000000000000800, 1'b0}; // jal +2048
    vecs[9]  = '{32'hFFFFF06F, 3'd4, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0}; // jal -2
    vecs[10] = '{32'h800000B7, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0}; // lui neg
    vecs[11] = '{32'hFFFFFFFF, 3'd6, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[12] = '{32'h12345678, 3'd5, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[13] = '{32'h00000013, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[14] = '{32'h0210D093, 3'd0, 32'h00000001, 64'h0000000000000021, 1'b0}; // srli 33

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_type = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid32", 64'(out_valid32), 64'd0);
    check("reset out_imm32",   64'(out_imm32),   64'd0);
    check("reset out_err32",   64'(out_err32),   64'd0);
    check("reset out_tag32",   64'(out_tag32),   64'd0);
    check("reset out_valid64", 64'(out_valid64), 64'd0);
    check("reset out_imm64",   out_imm64,        64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset in_ready32", 64'(in_ready32), 64'd1);
    check("post-reset in_ready64", 64'(in_ready64), 64'd1);

    // Table vectors streamed back to back with out_ready held high.
    in_valid = 1'b1; in_instr = vecs[0].instr; in_type = vecs[0].typ; in_tag = 5'd1;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid32", i), 64'(out_valid32), 64'd1);
      check($sformatf("vec%0d imm32", i), 64'(out_imm32), 64'(vecs[i].exp32));
      check($sformatf("vec%0d err32", i), 64'(out_err32), 64'(vecs[i].err));
      check($sformatf("vec%0d tag32", i), 64'(out_tag32), 64'(i + 1));
      check($sformatf("vec%0d imm64", i), out_imm64, vecs[i].exp64);
      check($sformatf("vec%0d err64", i), 64'(out_err64), 64'(vecs[i].err));
      check($sformatf("vec%0d tag64", i), 64'(out_tag64), 64'(i + 1));
      check($sformatf("vec%0d in_ready32", i), 64'(in_ready32), 64'd1);
      if (i + 1 < NV) begin
        in_instr = vecs[i+1].instr; in_type = vecs[i+1].typ; in_tag = 5'(i + 2);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("drained out_valid32", 64'(out_valid32), 64'd0);

    // Stall sequence: 4 items, out_ready low for cycles 0..2.
    sent = 0; got = 0; stalled = 0;
    held_imm32 = '0; held_imm64 = '0; held_tag = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (stalled) begin
        check($sformatf("stall c%0d imm32 stable", c), 64'(out_imm32), 64'(held_imm32));
        check($sformatf("stall c%0d imm64 stable", c), out_imm64, held_imm64);
        check($sformatf("stall c%0d tag stable", c), 64'(out_tag32), 64'(held_tag));
      end
      if (c == 1) check("stall in_ready after 1", 64'(in_ready32), 64'd1);
      if (c == 2) check("stall in_ready after 2", 64'(in_ready32), 64'd0);
      out_ready = (c >= 3);
      in_valid  = (sent < 4);
      in_instr  = {12'(sent + 5), 20'h00013};
      in_type   = 3'd0;
      in_tag    = 5'(sent + 10);
      if (out_valid32 && out_ready) begin
        et = (q_tag.size() > 0) ? q_tag.pop_front() : -1;
        ei = (q_imm.size() > 0) ? q_imm.pop_front() : -1;
        check($sformatf("stream item%0d tag", got), 64'(out_tag32), 64'(et));
        check($sformatf("stream item%0d imm32", got), 64'(out_imm32), 64'(ei));
        check($sformatf("stream item%0d imm64", got), out_imm64, 64'(ei));
        got++;
      end
      if (in_valid && in_ready32) begin
        q_tag.push_back(sent + 10);
        q_imm.push_back(sent + 5);
        sent++;
      end
      stalled    = out_valid32 && !out_ready;
      held_imm32 = out_imm32;
      held_imm64 = out_imm64;
      held_tag   = out_tag32;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("stream items received", 64'(got), 64'd4);
    check("stream nothing extra", 64'(out_valid32), 64'd0);

    // Fill both entries, then reset for one cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00700013; in_type = 3'd0; in_tag = 5'd21;
    @(posedge clk);
    #1;
    in_instr = 32'h00800013; in_tag = 5'd22;
    @(posedge clk);
    #1;
    check("full in_ready32", 64'(in_ready32), 64'd0);
    check("full out_valid32", 64'(out_valid32), 64'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset out_valid32", 64'(out_valid32), 64'd0);
    check("midreset out_imm32", 64'(out_imm32), 64'd0);
    check("midreset out_imm64", out_imm64, 64'd0);
    check("midreset out_tag32", 64'(out_tag32), 64'd0);
    check("midreset in_ready32", 64'(in_ready32), 64'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("no stale item c%0d", k), 64'(out_valid32), 64'd0);
      check($sformatf("no stale item64 c%0d", k), 64'(out_valid64), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender.
- Decodes the I, S, B, U and J immediates from a full 32-bit instruction, sign-extended to XLEN (RV32 or RV64).
- Shift-amount detection is opcode-qualified.
- Registered output stage with a 2-entry valid/ready skid buffer, so it can sit between the fetch/decode and execute stages of the pipelined core.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- TAG_W, 5, width of the opaque sideband tag (for example rd or a ROB index) carried alongside each immediate.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  block can accept an instruction this cycle.
- in_instr  in  32  full instruction word.
- in_type  in  3  format select: 0=I, 1=S, 2=B, 3=U, 4=J, 5..7 illegal.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  imm/tag/err are valid.
- out_ready  in  1  downstream accepts the current output.
- out_imm  out  XLEN  extended immediate.
- out_err  out  1  in_type was illegal.
- out_tag  out  TAG_W  tag of the current output.

Behaviour:
- Reset, synchronous, rst_n=0 at a clk edge:
  - out_valid=0, skid entry invalid, out_imm=0, out_err=0, out_tag=0.
  - in_ready=1 in the cycle after reset releases.
  - Reset mid-transfer discards both entries with no output.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_imm/out_err/out_tag must hold stable while out_valid && !out_ready.
- Latency: 1 cycle. An instruction accepted at edge N is presented at edge N+1 if the output register is empty or draining.
- Skid buffer:
  - in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
  - If an input transfers while the output is stalled, the result goes to the skid entry.
  - When the output drains, the skid entry moves to the output register.
  - If the input also transfers in that same cycle, the new result goes to the skid entry.
  - Full throughput: 1 item per cycle when out_ready stays 1. No loss and no duplication; order is preserved.
- Immediate rules, with i = in_instr and S(x) = sign-extend to XLEN:
  - I: S(i[31:20]).
  - S: S({i[31:25], i[11:7]}).
  - B: S({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - U: S({i[31:12], 12'b0}). Upper bits are sign-extended for XLEN=64.
  - J: S({i[31], i[19:12], i[20], i[30:21], 1'b0}).
- Shift exception (type I only): if i[14:12] is 001 or 101 the immediate is the zero-extended shift amount, as follows.
  - i[6:0]=0010011 gives i[25:20] when XLEN=64, else i[24:20].
  - i[6:0]=0011011 gives i[24:20]. This opcode is only recognised when XLEN=64.
  - Any other opcode (for example loads with funct3=101) uses the normal signed I rule.
- Illegal in_type: out_imm=0, out_err=1, and the item is still transferred normally. out_err=0 for legal types.
- Immediate decode is purely combinational into the stage registers; no state machine beyond the two valid bits.

Decomposition:
- Shared package imm_pkg:
  - format encodings IMM_I..IMM_J.
  - opcode constants OP_IMM=7'b0010011 and OP_IMM_32=7'b0011011.
  - funct3 constants F3_SLL=3'b001 and F3_SRL_SRA=3'b101.
- One combinational sub-module, imm_decode (parameter XLEN), holds the format mux and shift exception. imm_gen_pipe instantiates it and adds the skid registers.

Test Plan:
- XLEN=32, type I, instr 0xFFF00093 (addi -1), out_ready=1 -> one cycle later out_imm=0xFFFFFFFF, out_err=0.
- Type I, 0x4030D093 (srai 3) -> out_imm=0x00000003. Type I, 0xFFF05083 (lhu -1, funct3=101) -> out_imm=0xFFFFFFFF.
- Type B, 0xFE000EE3 (beq -4) -> 0xFFFFFFFC. Type U, 0x123450B7 with XLEN=64 -> 0x0000000012345000. Type I, 0x03F09093 (slli 63) with XLEN=64 -> 0x3F.
- Back-to-back stream of 4 items with out_ready low for 2 cycles:
  - in_ready must drop after exactly 2 accepted-but-unconsumed items.
  - All 4 items emerge in order with correct tags and imm held stable while stalled.
- in_type=6 with any instr -> out_imm=0, out_err=1, tag passed through.
- Assert rst_n=0 for one cycle while both entries are full -> next cycle out_valid=0, out_imm=0, in_ready=1, and no stale item appears afterwards.
